// File: rtl/serial_addsub_n.sv
// Bit-serial WIDTH-bit adder/subtractor with start/valid/done handshake, LSB first.
// Optional signed-overflow output enabled by defining SERIAL_ADDSUB_OVF_EN.
module serial_addsub_n #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic             in_valid,
  input  logic             a,
  input  logic             b,
  output logic             busy,
  output logic             out_valid,
  output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADDSUB_OVF_EN
  output logic             ovf,
`endif
  output logic             cout
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic             sub_q, sub_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
`ifdef SERIAL_ADDSUB_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic b_eff, s_bit, maj;

  // Subtraction is a + ~b + 1: invert b per bit and preload the carry with sub.
  assign b_eff = b ^ sub_q;
  assign s_bit = a ^ b_eff ^ carry_q;
  assign maj   = (a & b_eff) | (a & carry_q) | (b_eff & carry_q);

  always_comb begin
    state_d = state_q;
    sub_d   = sub_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
`ifdef SERIAL_ADDSUB_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          sub_d   = sub;
          carry_d = sub;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (in_valid) begin
          carry_d = maj;
          sum_d   = {s_bit, sum_q[WIDTH-1:1]};
          cnt_d   = cnt_q + CW'(1);
          // Last bit: carry out of the MSB is reported, never folded into sum.
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_d = DONE;
            cout_d  = maj;
`ifdef SERIAL_ADDSUB_OVF_EN
            ovf_d   = carry_q ^ maj;
`endif
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      sub_q   <= 1'b0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
`ifdef SERIAL_ADDSUB_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sub_q   <= sub_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
`ifdef SERIAL_ADDSUB_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
`ifdef SERIAL_ADDSUB_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule
